// File: rtl/slink_pwr_ctrl.sv
// Power sequencer for one Serial Link: orders clock gate, link reset and AXI isolation on up/down.
// Optional isolation watchdog enabled by defining SLINK_PWR_CTRL_TIMEOUT_EN.
module slink_pwr_ctrl #(
  parameter int unsigned NumIsolate    = 2,
  parameter int unsigned ClkWaitCycles = 4,
  parameter int unsigned RstWaitCycles = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [NumIsolate-1:0] isolated_i,
  output logic [NumIsolate-1:0] isolate_o,
  output logic                  clk_ena_o,
  output logic                  reset_no,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [2:0]            state_o,
  output logic                  timeout_o,
  input  logic                  clr_timeout_i
);

  localparam int unsigned MaxWait01 =
      (ClkWaitCycles > RstWaitCycles) ? ClkWaitCycles : RstWaitCycles;
  localparam int unsigned MaxWait   = (MaxWait01 > TimeoutCycles) ? MaxWait01 : TimeoutCycles;
  localparam int unsigned CntW      = $clog2(MaxWait) + 1;

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StClkOn  = 3'd1,
    StRstRel = 3'd2,
    StDeiso  = 3'd3,
    StOn     = 3'd4,
    StIso    = 3'd5,
    StRstAss = 3'd6,
    StClkOff = 3'd7
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NumIsolate-1:0]   isolate_q, isolate_d;
  logic                    clk_ena_q, clk_ena_d;
  logic                    reset_n_q, reset_n_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    all_iso, none_iso;
  logic                    clk_done, rst_done;
  logic                    wd_fire;

  assign all_iso  = &isolated_i;
  assign none_iso = ~|isolated_i;
  assign clk_done = (cnt_q == CntW'(ClkWaitCycles - 1));
  assign rst_done = (cnt_q == CntW'(RstWaitCycles - 1));

`ifdef SLINK_PWR_CTRL_TIMEOUT_EN
  logic timeout_q, timeout_d;

  // The dwell counter is cleared on ISO entry, so it doubles as the watchdog count.
  assign wd_fire = (state_q == StIso) && !all_iso && (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    timeout_d = timeout_q;
    if (clr_timeout_i) timeout_d = 1'b0;
    if (wd_fire)       timeout_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_q <= 1'b0;
    else         timeout_q <= timeout_d;
  end

  assign timeout_o = timeout_q;
`else
  logic unused_clr_timeout;
  assign unused_clr_timeout = clr_timeout_i;
  assign wd_fire            = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff:    if (enable_i)           state_d = StClkOn;
      StClkOn:  if (clk_done)           state_d = StRstRel;
      StRstRel: if (rst_done)           state_d = StDeiso;
      StDeiso:  if (none_iso)           state_d = StOn;
      StOn:     if (!enable_i)          state_d = StIso;
      StIso:    if (all_iso || wd_fire) state_d = StRstAss;
      StRstAss: if (rst_done)           state_d = StClkOff;
      StClkOff: if (clk_done)           state_d = StOff;
      default:                          state_d = StOff;
    endcase
  end

  // Saturating dwell counter, restarted on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so each one is a clean register output.
  always_comb begin
    isolate_d = '1;
    clk_ena_d = 1'b1;
    reset_n_d = 1'b0;
    ready_d   = 1'b0;
    busy_d    = 1'b1;
    case (state_d)
      StOff: begin
        clk_ena_d = 1'b0;
        busy_d    = 1'b0;
      end
      StRstRel: reset_n_d = 1'b1;
      StDeiso: begin
        reset_n_d = 1'b1;
        isolate_d = '0;
      end
      StOn: begin
        reset_n_d = 1'b1;
        isolate_d = '0;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
      end
      StIso:   reset_n_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StOff;
      cnt_q     <= '0;
      isolate_q <= '1;
      clk_ena_q <= 1'b0;
      reset_n_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isolate_q <= isolate_d;
      clk_ena_q <= clk_ena_d;
      reset_n_q <= reset_n_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign isolate_o = isolate_q;
  assign clk_ena_o = clk_ena_q;
  assign reset_no  = reset_n_q;
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign state_o   = state_q;

endmodule
